// File: rtl/key_direction_filter.sv
// key_direction_filter: conditions the four active-low push-buttons and
// turns clean presses into a legal direction command. The command waits in
// a one-deep buffer until the game controller consumes it with dir_ack.
// The per-key lane synchronises and debounces one button. The top module
// turns each debounced rising level into a one-cycle press and arbitrates
// the presses into the command buffer.

module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic clk_50MHz,
  input  logic reset,
  input  logic key_n,
  output logic level
);

  logic [1:0]       sync;
  logic             sync_p;
  logic [CNT_W-1:0] cnt;

  // Two-flop synchroniser. It resets to "released" so that reset produces no false press.
  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) sync <= 2'b11;
    else       sync <= {sync[0], key_n};
  end

  assign sync_p = ~sync[1];

  // Count consecutive disagreeing cycles. Toggle the level on the cycle that would reach the limit.
  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (sync_p == level) begin
      cnt <= '0;
    end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      cnt   <= '0;
      level <= ~level;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

module key_direction_filter #(
  parameter int DEBOUNCE_CYCLES = 1000000,  // must be >= 2
  parameter int CNT_W           = 20        // 2**CNT_W > DEBOUNCE_CYCLES
) (
  input  logic       clk_50MHz,
  input  logic       reset,
  input  logic [3:0] key_n,
  input  logic [1:0] cur_dir,
  input  logic       dir_ack,
  output logic [3:0] key_level,
  output logic [3:0] key_press,
  output logic       dir_valid,
  output logic [1:0] dir_cmd
);

  localparam int NUM_LANES = 4;

  logic [NUM_LANES-1:0] key_level_d;
  logic [1:0]           cand;
  logic                 accept;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_deb [NUM_LANES-1:0] (
    .clk_50MHz(clk_50MHz),
    .reset    (reset),
    .key_n    (key_n),
    .level    (key_level)
  );

  // Delay the debounced level by one cycle to detect its rising edge.
  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) key_level_d <= '0;
    else       key_level_d <= key_level;
  end

  assign key_press = key_level & ~key_level_d;

  // Select the lowest pressed key. Reject it if it is on the current
  // direction's axis, because UP/DOWN and LEFT/RIGHT differ only in bit 0.
  always_comb begin
    cand = 2'd0;
    for (int i = NUM_LANES - 1; i >= 0; i--)
      if (key_press[i]) cand = 2'(i);
    accept = (key_press != '0) && (cand[1] != cur_dir[1]);
  end

  // One-deep command buffer. The newest accepted press overwrites the held
  // command. An ack clears the buffer unless a new command arrives in the same cycle.
  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) begin
      dir_valid <= 1'b0;
      dir_cmd   <= 2'b11;
    end else if (accept) begin
      dir_valid <= 1'b1;
      dir_cmd   <= cand;
    end else if (dir_ack) begin
      dir_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_key_direction_filter.sv
// Bench for key_direction_filter with a short debounce (4 cycles). It uses
// hand sequences for the latency and reset corners, a vector table for
// direction rules, and random stimulus against a rule-level model.

module tb_key_direction_filter;

  localparam int D = 4;

  logic       clk_50MHz = 1'b0;
  logic       reset;
  logic [3:0] key_n;
  logic [1:0] cur_dir;
  logic       dir_ack;
  logic [3:0] key_level;
  logic [3:0] key_press;
  logic       dir_valid;
  logic [1:0] dir_cmd;

  int checks = 0;
  int errors = 0;

  key_direction_filter #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
    .clk_50MHz(clk_50MHz),
    .reset    (reset),
    .key_n    (key_n),
    .cur_dir  (cur_dir),
    .dir_ack  (dir_ack),
    .key_level(key_level),
    .key_press(key_press),
    .dir_valid(dir_valid),
    .dir_cmd  (dir_cmd)
  );

  always #5 clk_50MHz = ~clk_50MHz;

  // Reference model. A raw sample reaches the filter two edges later. The
  // filter's level flips after D consecutive edges of disagreement. A press
  // is a rising level. Keys on the current direction's axis (pairs 0/1 and 2/3) are refused.
  logic [3:0] s1, s2, m_lvl, m_lvl_d;
  int         run [4];
  logic       m_vld;
  logic [1:0] m_cmd;
  wire  [3:0] m_press = m_lvl & ~m_lvl_d;

  always @(posedge clk_50MHz or posedge reset) begin
    if (reset) begin
      s1 <= '1; s2 <= '1; m_lvl <= '0; m_lvl_d <= '0;
      m_vld <= 1'b0; m_cmd <= 2'd3;
      for (int i = 0; i < 4; i++) run[i] <= 0;
    end else begin
      int         c;
      logic [3:0] nl;
      c = -1;
      for (int i = 0; i < 4; i++) if (m_press[i] && c < 0) c = i;
      if (c >= 0 && (c / 2) != (int'(cur_dir) / 2)) begin
        m_vld <= 1'b1;
        m_cmd <= 2'(c);
      end else if (dir_ack) begin
        m_vld <= 1'b0;
      end
      nl = m_lvl;
      for (int i = 0; i < 4; i++) begin
        if (!s2[i] != m_lvl[i]) begin
          if (run[i] + 1 == D) begin nl[i] = ~m_lvl[i]; run[i] <= 0; end
          else run[i] <= run[i] + 1;
        end else run[i] <= 0;
      end
      m_lvl_d <= m_lvl;
      m_lvl   <= nl;
      s2      <= s1;
      s1      <= key_n;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk_50MHz);
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_level"}, 32'(key_level), 0);
    chk({nm, "_press"}, 32'(key_press), 0);
    chk({nm, "_valid"}, 32'(dir_valid), 0);
    chk({nm, "_cmd"},   32'(dir_cmd),   3);
  endtask

  typedef struct {
    string      name;
    logic [3:0] kn;
    logic [1:0] cd;
    logic       ack;
    int         cyc;
    logic [3:0] e_level;
    logic       e_valid;
    logic [1:0] e_cmd;
  } vec_t;

  vec_t vt [15];

  initial begin
    int n;
    logic [3:0] seen;
    logic [3:0] k;

    vt[0]  = '{"idle",         4'hF,    2'd3, 1'b0, 10, 4'b0000, 1'b0, 2'd0};
    vt[1]  = '{"left_vs_rt",   4'b1011, 2'd3, 1'b0, 10, 4'b0100, 1'b0, 2'd0};
    vt[2]  = '{"rel_left",     4'hF,    2'd3, 1'b0, 10, 4'b0000, 1'b0, 2'd0};
    vt[3]  = '{"right_same",   4'b0111, 2'd3, 1'b0, 10, 4'b1000, 1'b0, 2'd0};
    vt[4]  = '{"rel_right",    4'hF,    2'd3, 1'b0, 10, 4'b0000, 1'b0, 2'd0};
    vt[5]  = '{"prio_l_r",     4'b0011, 2'd0, 1'b0, 10, 4'b1100, 1'b1, 2'd2};
    vt[6]  = '{"rel_both",     4'hF,    2'd0, 1'b0, 10, 4'b0000, 1'b1, 2'd2};
    vt[7]  = '{"overwrite_r",  4'b0111, 2'd0, 1'b0, 10, 4'b1000, 1'b1, 2'd3};
    vt[8]  = '{"rel_r2",       4'hF,    2'd0, 1'b0, 10, 4'b0000, 1'b1, 2'd3};
    vt[9]  = '{"ack_clear",    4'hF,    2'd0, 1'b1, 1,  4'b0000, 1'b0, 2'd3};
    vt[10] = '{"ack_idle",     4'hF,    2'd0, 1'b1, 3,  4'b0000, 1'b0, 2'd3};
    vt[11] = '{"up_vs_down",   4'b1110, 2'd1, 1'b0, 10, 4'b0001, 1'b0, 2'd3};
    vt[12] = '{"rel_up",       4'hF,    2'd1, 1'b0, 10, 4'b0000, 1'b0, 2'd3};
    vt[13] = '{"down_vs_left", 4'b1101, 2'd2, 1'b0, 10, 4'b0010, 1'b1, 2'd1};
    vt[14] = '{"rel_down",     4'hF,    2'd2, 1'b0, 10, 4'b0000, 1'b1, 2'd1};

    // Reset and idle.
    reset = 1'b1; key_n = 4'hF; cur_dir = 2'd3; dir_ack = 1'b0;
    step(3);
    chk_reset_vals("reset");
    reset = 1'b0;
    step(50);
    chk_reset_vals("idle50");

    // Clean press of UP. The raw low is first sampled at edge E.
    key_n = 4'b1110;
    step(5);  // after E+4
    chk("press_lvl_early", 32'(key_level), 0);
    step(1);  // after E+5
    chk("press_lvl", 32'(key_level), 1);
    chk("press_pulse", 32'(key_press), 1);
    chk("press_valid_early", 32'(dir_valid), 0);
    step(1);  // after E+6
    chk("press_pulse_end", 32'(key_press), 0);
    chk("press_valid", 32'(dir_valid), 1);
    chk("press_cmd", 32'(dir_cmd), 0);
    dir_ack = 1'b1;
    step(1);
    dir_ack = 1'b0;
    chk("ack_clear", 32'(dir_valid), 0);
    n = 0;
    for (int i = 0; i < 100; i++) begin step(1); if (key_press != 0) n++; end
    chk("hold_no_repress", 32'(n), 0);
    key_n = 4'hF;
    step(10);
    chk("release_lvl", 32'(key_level), 0);

    // A glitch of three low samples must not change the level.
    key_n = 4'b1110;
    step(3);
    key_n = 4'hF;
    seen = '0;
    for (int i = 0; i < 12; i++) begin step(1); seen |= key_level; end
    chk("glitch_no_lvl", 32'(seen), 0);
    key_n = 4'b1110;
    step(10);
    chk("full_press_lvl", 32'(key_level), 1);
    key_n = 4'hF;
    seen = '0;
    for (int i = 0; i < 10; i++) begin step(1); seen |= key_press; end
    chk("release_no_press", 32'(seen), 0);
    chk("release_lvl2", 32'(key_level), 0);
    dir_ack = 1'b1; step(1); dir_ack = 1'b0;

    // Vector table: direction rules, priority, overwrite, ack.
    for (int v = 0; v < 15; v++) begin
      key_n = vt[v].kn; cur_dir = vt[v].cd; dir_ack = vt[v].ack;
      step(vt[v].cyc);
      dir_ack = 1'b0;
      chk({vt[v].name, "_lvl"},   32'(key_level), 32'(vt[v].e_level));
      chk({vt[v].name, "_valid"}, 32'(dir_valid), 32'(vt[v].e_valid));
      chk({vt[v].name, "_cmd"},   32'(dir_cmd),   32'(vt[v].e_cmd));
    end

    // An ack in the same cycle as a new accepted press keeps valid set.
    cur_dir = 2'd0;
    key_n = 4'b1011;
    step(6);  // after E+5, the press is visible
    chk("ackpress_pulse", 32'(key_press), 4);
    dir_ack = 1'b1;
    step(1);
    dir_ack = 1'b0;
    chk("ackpress_valid", 32'(dir_valid), 1);
    chk("ackpress_cmd", 32'(dir_cmd), 2);
    key_n = 4'hF;
    step(10);

    // Reset mid-operation, with a RIGHT count at 3 and a command pending.
    key_n = 4'b0111;
    step(5);  // after E+4, the count is 3
    chk("mid_valid_pre", 32'(dir_valid), 1);
    #2 reset = 1'b1;
    #1 chk_reset_vals("async_reset");
    step(1);
    reset = 1'b0;
    step(5);
    chk("post_reset_lvl_early", 32'(key_level), 0);
    step(1);
    chk("post_reset_lvl", 32'(key_level), 8);
    key_n = 4'hF;
    step(10);

    // Random stimulus against the model.
    #2 reset = 1'b1;
    step(1);
    reset = 1'b0;
    k = 4'hF;
    for (int c = 0; c < 3000; c++) begin
      step(1);
      chk("rnd_level", 32'(key_level), 32'(m_lvl));
      chk("rnd_press", 32'(key_press), 32'(m_press));
      chk("rnd_valid", 32'(dir_valid), 32'(m_vld));
      chk("rnd_cmd",   32'(dir_cmd),   32'(m_cmd));
      for (int i = 0; i < 4; i++) if ($urandom_range(0, 5) == 0) k[i] = ~k[i];
      key_n = k;
      if ($urandom_range(0, 7) == 0) cur_dir = 2'($urandom_range(0, 3));
      dir_ack = ($urandom_range(0, 2) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
